// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: issues fetches, advances pc on ack,
// applies jump/ret redirects and maintains a small circular return-address stack.
module pc_sequencer #(
   parameter int unsigned    PC_W      = 16,
   parameter int unsigned    RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            fetch_req,
   output logic [PC_W-1:0] fetch_addr,
   input  logic            fetch_ack,
   input  logic            stall,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_pc,
   input  logic            br_jump,
   input  logic            br_ret,
   input  logic            br_call,
   input  logic [PC_W-1:0] br_target,
   output logic            flush,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   localparam int unsigned SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic [1:0]      state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [SP_W-1:0] sp, sp_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [PC_W-1:0] ras [RAS_DEPTH];
   logic [PC_W-1:0] ras_top;
   logic            push_en;
   logic            flush_nxt, ovf_nxt, unf_nxt;
   logic            active, redirect, do_ret, do_push;

   // Request is combinational from state (and stall in REQ) so reset drops it at once.
   assign fetch_req  = ((state == S_REQ) && !stall) || (state == S_WAIT);
   assign fetch_addr = pc;

   assign ras_top  = ras[sp - SP_W'(1)];
   assign active   = (state == S_REQ) || (state == S_WAIT);
   assign redirect = active && br_valid && (br_ret || br_jump);
   assign do_ret   = redirect && br_ret;
   assign do_push  = active && br_valid && br_call && br_jump && !br_ret;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_BOOT;
         pc            <= RESET_PC;
         sp            <= '0;
         count         <= '0;
         flush         <= 1'b0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         sp            <= sp_nxt;
         count         <= count_nxt;
         flush         <= flush_nxt;
         ras_overflow  <= ovf_nxt;
         ras_underflow <= unf_nxt;
      end
   end

   // Return-address storage; a push writes at sp, overwriting the oldest when full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) ras[i] <= '0;
      end else if (push_en) begin
         ras[sp] <= br_pc + PC_W'(1);
      end
   end

   // Next-state, pc and RAS pointer logic; redirect overrides ack and stall
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      sp_nxt    = sp;
      count_nxt = count;
      push_en   = 1'b0;
      flush_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;

      case (state)
         S_BOOT:  state_nxt = S_REQ;
         S_REQ: begin
            if (fetch_req && fetch_ack) begin
               pc_nxt = pc + PC_W'(1);
            end else if (fetch_req) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fetch_ack) begin
               pc_nxt    = pc + PC_W'(1);
               state_nxt = S_REQ;
            end
         end
         S_FLUSH: state_nxt = S_REQ;
         default: state_nxt = S_BOOT;
      endcase

      if (redirect) begin
         state_nxt = S_FLUSH;
         flush_nxt = 1'b1;
         if (do_ret && (count != '0)) begin
            pc_nxt    = ras_top;
            sp_nxt    = sp - SP_W'(1);
            count_nxt = count - CNT_W'(1);
         end else begin
            pc_nxt  = br_target;
            unf_nxt = do_ret;
         end
      end

      if (do_push) begin
         push_en = 1'b1;
         sp_nxt  = sp + SP_W'(1);
         if (count == CNT_W'(RAS_DEPTH)) begin
            ovf_nxt = 1'b1;
         end else begin
            count_nxt = count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus pushes hand-computed
// output snapshots; a monitor pops one whenever the DUT shows any output activity.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ack;
   logic        stall;
   logic        br_valid;
   logic [15:0] br_pc;
   logic        br_jump;
   logic        br_ret;
   logic        br_call;
   logic [15:0] br_target;
   logic        flush;
   logic        ras_overflow;
   logic        ras_underflow;

   typedef struct packed {
      logic        req;
      logic [15:0] addr;
      logic        fl;
      logic        ov;
      logic        un;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   pc_sequencer #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .stall(stall), .br_valid(br_valid), .br_pc(br_pc), .br_jump(br_jump),
      .br_ret(br_ret), .br_call(br_call), .br_target(br_target),
      .flush(flush), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: any visible output activity must match the next expected snapshot
   always @(negedge clk) begin
      if (rst_n && (fetch_req || flush || ras_overflow || ras_underflow)) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output t=%0t req=%b addr=%h flush=%b ovf=%b unf=%b",
                     $time, fetch_req, fetch_addr, flush, ras_overflow, ras_underflow);
         end else begin
            e = q.pop_front();
            if ({fetch_req, fetch_addr, flush, ras_overflow, ras_underflow} !==
                {e.req, e.addr, e.fl, e.ov, e.un}) begin
               failures++;
               $display("FAIL output_snapshot t=%0t got req=%b addr=%h flush=%b ovf=%b unf=%b want req=%b addr=%h flush=%b ovf=%b unf=%b",
                        $time, fetch_req, fetch_addr, flush, ras_overflow, ras_underflow,
                        e.req, e.addr, e.fl, e.ov, e.un);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic exp(input logic r, input logic [15:0] a, input logic fl, input logic ov,
                      input logic un);
      exp_t e;
      e.req = r; e.addr = a; e.fl = fl; e.ov = ov; e.un = un;
      q.push_back(e);
   endtask

   task automatic cyc(input logic s, input logic a);
      @(posedge clk); #1;
      stall = s; fetch_ack = a;
      br_valid = 1'b0; br_jump = 1'b0; br_ret = 1'b0; br_call = 1'b0;
      br_pc = 16'h0; br_target = 16'h0;
   endtask

   task automatic brn(input logic s, input logic a, input logic j, input logic r,
                      input logic c, input logic [15:0] bpc, input logic [15:0] bt);
      @(posedge clk); #1;
      stall = s; fetch_ack = a;
      br_valid = 1'b1; br_jump = j; br_ret = r; br_call = c;
      br_pc = bpc; br_target = bt;
   endtask

   // Plain fetch cycle in REQ/WAIT expecting an active request at addr
   task automatic req(input logic a, input logic [15:0] addr);
      cyc(1'b0, a);
      exp(1'b1, addr, 1'b0, 1'b0, 1'b0);
   endtask

   // FLUSH cycle after a redirect
   task automatic flu(input logic [15:0] addr, input logic ov, input logic un);
      cyc(1'b0, 1'b1);
      exp(1'b0, addr, 1'b1, ov, un);
   endtask

   initial begin
      logic [15:0] cur;
      logic [15:0] rets [4];
      rets[0] = 16'h6; rets[1] = 16'h5; rets[2] = 16'h4; rets[3] = 16'h3;

      rst_n = 1'b0; stall = 1'b0; fetch_ack = 1'b0;
      br_valid = 1'b0; br_jump = 1'b0; br_ret = 1'b0; br_call = 1'b0;
      br_pc = 16'h0; br_target = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_fetch_req", 32'(fetch_req), 32'd0);
      chk("reset_fetch_addr", 32'(fetch_addr), 32'd0);
      chk("reset_flush", 32'(flush), 32'd0);
      chk("reset_ovf", 32'(ras_overflow), 32'd0);
      chk("reset_unf", 32'(ras_underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fetch_ack = 1'b1;

      // Sequential fetch
      req(1, 16'h0); req(1, 16'h1); req(1, 16'h2); req(1, 16'h3); req(1, 16'h4);
      // Three wait cycles at 5, then ack
      req(0, 16'h5); req(0, 16'h5); req(0, 16'h5); req(1, 16'h5);
      req(1, 16'h6);
      // Stall in REQ: no request, pc frozen at 7
      cyc(1, 1); cyc(1, 1);
      req(0, 16'h7);
      // Stall ignored in WAIT
      cyc(1, 0); exp(1, 16'h7, 0, 0, 0);
      cyc(1, 1); exp(1, 16'h7, 0, 0, 0);
      req(1, 16'h8);

      // Taken jump with simultaneous ack; br_valid during FLUSH is ignored
      brn(0, 1, 1, 0, 0, 16'h0, 16'h40); exp(1, 16'h9, 0, 0, 0);
      brn(0, 1, 1, 0, 0, 16'h0, 16'h99); exp(0, 16'h40, 1, 0, 0);
      req(1, 16'h40); req(1, 16'h41);

      // Call / return / ret on empty RAS
      brn(0, 1, 1, 0, 1, 16'h10, 16'h80); exp(1, 16'h42, 0, 0, 0);
      flu(16'h80, 0, 0);
      req(1, 16'h80);
      brn(0, 0, 0, 1, 0, 16'h0, 16'h55); exp(1, 16'h81, 0, 0, 0);
      flu(16'h11, 0, 0);
      brn(0, 0, 0, 1, 0, 16'h0, 16'h22); exp(1, 16'h11, 0, 0, 0);
      flu(16'h22, 0, 1);

      // Redirect from WAIT while stalled
      req(0, 16'h22);
      brn(1, 0, 1, 0, 0, 16'h0, 16'h30); exp(1, 16'h22, 0, 0, 0);
      flu(16'h30, 0, 0);
      req(1, 16'h30);

      // Five calls into a 4-deep RAS, overflow on the fifth
      cur = 16'h31;
      for (int i = 1; i <= 5; i++) begin
         brn(0, 1, 1, 0, 1, 16'(i), 16'(16'h100 + i)); exp(1, cur, 0, 0, 0);
         flu(16'(16'h100 + i), (i == 5), 0);
         cur = 16'(16'h100 + i);
      end
      for (int k = 0; k < 4; k++) begin
         brn(0, 1, 0, 1, 0, 16'h0, 16'h0EEE); exp(1, cur, 0, 0, 0);
         flu(rets[k], 0, 0);
         cur = rets[k];
      end

      // Not-taken call leaves RAS empty; following ret underflows
      brn(0, 1, 0, 0, 1, 16'h3, 16'h77); exp(1, 16'h3, 0, 0, 0);
      brn(0, 1, 0, 1, 0, 16'h0, 16'h60); exp(1, 16'h4, 0, 0, 0);
      flu(16'h60, 0, 1);

      // PC wrap
      brn(0, 1, 1, 0, 0, 16'h0, 16'hFFFF); exp(1, 16'h60, 0, 0, 0);
      flu(16'hFFFF, 0, 0);
      req(1, 16'hFFFF);
      req(1, 16'h0000);

      // Push a call, enter WAIT, then reset asynchronously
      brn(0, 0, 1, 0, 1, 16'h20, 16'h200); exp(1, 16'h1, 0, 0, 0);
      flu(16'h200, 0, 0);
      req(0, 16'h200);
      @(posedge clk); #1;
      stall = 1'b0; fetch_ack = 1'b0;
      chk("wait_fetch_req", 32'(fetch_req), 32'd1);
      chk("wait_fetch_addr", 32'(fetch_addr), 32'h200);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_fetch_req", 32'(fetch_req), 32'd0);
      chk("async_reset_fetch_addr", 32'(fetch_addr), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req(1, 16'h0); req(1, 16'h1);
      brn(0, 1, 0, 1, 0, 16'h0, 16'h33); exp(1, 16'h2, 0, 0, 0);
      flu(16'h33, 0, 1);
      cyc(1, 0); cyc(1, 0);
      @(posedge clk); #1;

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
